// File: rtl/video_timing_tx_if.sv
// Ready/valid pixel stream with frame/line markers feeding video_timing_tx.
`timescale 1ns/1ps
interface video_timing_tx_if;
  logic [23:0] s_pixel;
  logic        s_valid;
  logic        s_sof;
  logic        s_eol;
  logic        s_ready;

  modport master (output s_pixel, s_valid, s_sof, s_eol, input s_ready);
  modport slave  (input s_pixel, s_valid, s_sof, s_eol, output s_ready);
endinterface

// File: rtl/video_timing_tx.sv
// Pixel-clock raster generator that paces a ready/valid pixel stream onto
// DE/HSYNC/VSYNC/RGB, locking to start-of-frame and realigning on stream errors.
`timescale 1ns/1ps
module video_timing_tx #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input  logic                tx_pclk,
  input  logic                tx_rst_n,
  input  logic                enable,
  video_timing_tx_if.slave    s_if,
  output logic                tx_de,
  output logic                tx_hsync,
  output logic                tx_vsync,
  output logic [7:0]          tx_red,
  output logic [7:0]          tx_green,
  output logic [7:0]          tx_blue,
  output logic [11:0]         x_pos,
  output logic [10:0]         y_pos,
  output logic                frame_start,
  output logic                locked,
  output logic                underflow
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] H_EOL    = 12'(H_ACTIVE - 1);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, ALIGN, STREAM} state_t;

  state_t      state_q, state_d;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        de_q, de_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [23:0] rgb_q, rgb_d;
  logic [11:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        fs_q, fs_d;
  logic        locked_q, locked_d;
  logic        uf_q, uf_d;

  logic active, at_origin, at_last, stream_err;

  always_comb begin
    active     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    at_origin  = (h_cnt_q == '0) && (v_cnt_q == '0);
    at_last    = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    // Marker checks only matter for a pixel actually offered in an active slot.
    stream_err = (state_q == STREAM) && active &&
                 (!s_if.s_valid ||
                  (s_if.s_sof && !at_origin) ||
                  (s_if.s_eol != (h_cnt_q == H_EOL)));

    // In ALIGN, junk is drained while the SOF pixel is held for the frame wrap.
    unique case (state_q)
      ALIGN:   s_if.s_ready = !(s_if.s_valid && s_if.s_sof);
      STREAM:  s_if.s_ready = active;
      default: s_if.s_ready = 1'b0;
    endcase

    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = ALIGN;
        ALIGN:   if (at_last && s_if.s_valid && s_if.s_sof) state_d = STREAM;
        STREAM:  if (stream_err) state_d = ALIGN;
        default: state_d = IDLE;
      endcase
    end

    h_cnt_d = '0;
    v_cnt_d = '0;
    if (enable) begin
      if (h_cnt_q == H_LAST) begin
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
      end else begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
      end
    end

    de_d     = enable && active;
    hs_d     = (enable && (h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
    vs_d     = (enable && (v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
    rgb_d    = (enable && (state_q == STREAM) && active && !stream_err) ? s_if.s_pixel : '0;
    x_d      = enable ? h_cnt_q : '0;
    y_d      = enable ? v_cnt_q : '0;
    fs_d     = enable && at_origin;
    uf_d     = enable && stream_err;
    locked_d = (state_d == STREAM);
  end

  always_ff @(posedge tx_pclk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state_q  <= IDLE;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      de_q     <= 1'b0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      rgb_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      fs_q     <= 1'b0;
      locked_q <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      de_q     <= de_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      rgb_q    <= rgb_d;
      x_q      <= x_d;
      y_q      <= y_d;
      fs_q     <= fs_d;
      locked_q <= locked_d;
      uf_q     <= uf_d;
    end
  end

  assign tx_de       = de_q;
  assign tx_hsync    = hs_q;
  assign tx_vsync    = vs_q;
  assign tx_red      = rgb_q[23:16];
  assign tx_green    = rgb_q[15:8];
  assign tx_blue     = rgb_q[7:0];
  assign x_pos       = x_q;
  assign y_pos       = y_q;
  assign frame_start = fs_q;
  assign locked      = locked_q;
  assign underflow   = uf_q;

endmodule

// File: tb/tb_video_timing_tx.sv
// Scoreboard bench for video_timing_tx on a 14x7 raster (98-cycle frame).
`timescale 1ns/1ps
module tb_video_timing_tx;

  typedef struct packed {
    logic [23:0] d;
    logic        sof;
    logic        eol;
  } pix_t;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
    logic [11:0] x;
    logic [10:0] y;
    logic        fs;
    logic        lk;
    logic        uf;
  } exp_t;

  logic        tx_pclk = 1'b0;
  logic        tx_rst_n;
  logic        enable;
  logic        tx_de, tx_hsync, tx_vsync;
  logic [7:0]  tx_red, tx_green, tx_blue;
  logic [11:0] x_pos;
  logic [10:0] y_pos;
  logic        frame_start, locked, underflow;

  video_timing_tx_if vif ();

  video_timing_tx #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .tx_pclk(tx_pclk), .tx_rst_n(tx_rst_n), .enable(enable),
    .s_if(vif.slave),
    .tx_de(tx_de), .tx_hsync(tx_hsync), .tx_vsync(tx_vsync),
    .tx_red(tx_red), .tx_green(tx_green), .tx_blue(tx_blue),
    .x_pos(x_pos), .y_pos(y_pos), .frame_start(frame_start),
    .locked(locked), .underflow(underflow)
  );

  always #5 tx_pclk = ~tx_pclk;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  pix_t pq[$];

  // Bench model state: 0 idle, 1 align, 2 stream.
  int   mst = 0;
  int   mh = 0;
  int   mv = 0;
  logic en_req = 1'b0;
  logic stream_on = 1'b0;
  int   fault_kind = 0;
  int   fx = 0;
  int   fy = 0;
  logic dis_armed = 1'b0;

  logic fs_chk = 1'b0;
  int   last_fs = -1;
  int   cyc = 0;
  int   uf_seen = 0;
  int   seen_023 = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic drive_cycle();
    pix_t h;
    logic en_now, valid, exp_rdy, act, err;
    int   nst;
    exp_t e;
    en_now = en_req;
    if (dis_armed && mst == 2 && mh == 3 && mv == 1) begin
      en_now = 1'b0; en_req = 1'b0; dis_armed = 1'b0;
    end
    h = (pq.size() > 0) ? pq[0] : '0;
    valid = stream_on && (pq.size() > 0);
    if (fault_kind != 0 && en_now && mst == 2 && mh == fx && mv == fy) begin
      case (fault_kind)
        1: valid = 1'b0;
        2: h.eol = 1'b1;
        default: h.sof = 1'b1;
      endcase
      fault_kind = 0;
    end
    enable = en_now;
    vif.s_valid = valid;
    vif.s_pixel = h.d;
    vif.s_sof = h.sof;
    vif.s_eol = h.eol;

    @(negedge tx_pclk);
    act = (mh < 8) && (mv < 4);
    exp_rdy = (mst == 0) ? 1'b0 : (mst == 1) ? !(valid && h.sof) : act;
    chk("s_ready", vif.s_ready, exp_rdy);
    e = '0;
    if (!en_now) begin
      mst = 0; mh = 0; mv = 0;
    end else begin
      err = (mst == 2) && act &&
            (!valid || (h.sof && (mh != 0 || mv != 0)) || (h.eol != (mh == 7)));
      e.de  = act;
      e.hs  = (mh >= 10) && (mh < 12);
      e.vs  = (mv == 5);
      e.x   = 12'(mh);
      e.y   = 11'(mv);
      e.fs  = (mh == 0) && (mv == 0);
      e.rgb = (mst == 2 && act && !err) ? h.d : 24'h0;
      e.uf  = err;
      if (mst == 0)      nst = 1;
      else if (mst == 1) nst = (mh == 13 && mv == 6 && valid && h.sof) ? 2 : 1;
      else               nst = err ? 1 : 2;
      e.lk = (nst == 2);
      mst = nst;
      if (mh == 13) begin mh = 0; mv = (mv == 6) ? 0 : mv + 1; end
      else mh = mh + 1;
    end
    sbq.push_back(e);
    if (exp_rdy && valid) void'(pq.pop_front());
    @(posedge tx_pclk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive_cycle();
  endtask

  // Monitor: compares each registered output word against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge tx_pclk);
      #2;
      cyc++;
      if (underflow) uf_seen++;
      if (fs_chk && frame_start) begin
        if (last_fs >= 0) chk("frame_period", cyc - last_fs, 98);
        last_fs = cyc;
      end
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("tx_de", tx_de, e.de);
        chk("tx_hsync", tx_hsync, e.hs);
        chk("tx_vsync", tx_vsync, e.vs);
        chk("rgb", {tx_red, tx_green, tx_blue}, e.rgb);
        chk("x_pos", x_pos, e.x);
        chk("y_pos", y_pos, e.y);
        chk("frame_start", frame_start, e.fs);
        chk("locked", locked, e.lk);
        chk("underflow", underflow, e.uf);
        if (locked && x_pos == 12'd3 && y_pos == 11'd2 &&
            {tx_red, tx_green, tx_blue} == 24'h000023) seen_023++;
      end
    end
  end

  initial begin
    int de_cnt;
    tx_rst_n = 1'b0;
    enable = 1'b0;
    vif.s_valid = 1'b0;
    vif.s_pixel = '0;
    vif.s_sof = 1'b0;
    vif.s_eol = 1'b0;
    #1;
    chk("rst_de", tx_de, 0);
    chk("rst_hsync", tx_hsync, 0);
    chk("rst_vsync", tx_vsync, 0);
    chk("rst_rgb", {tx_red, tx_green, tx_blue}, 0);
    chk("rst_locked", locked, 0);
    chk("rst_ready", vif.s_ready, 0);
    repeat (2) @(negedge tx_pclk);
    tx_rst_n = 1'b1;
    @(posedge tx_pclk);
    #1;

    run(50);

    en_req = 1'b1;
    fs_chk = 1'b1;
    de_cnt = 0;
    for (int i = 0; i < 196; i++) begin
      drive_cycle();
      de_cnt += int'(tx_de);
    end
    chk("raster_de_count", de_cnt, 64);
    fs_chk = 1'b0;

    for (int i = 0; i < 2; i++) pq.push_back('{d: 24'hABCDEF, sof: 1'b0, eol: 1'b0});
    for (int f = 0; f < 24; f++)
      for (int y = 0; y < 4; y++)
        for (int x = 0; x < 8; x++)
          pq.push_back('{d: 24'((y << 4) | x), sof: (x == 0 && y == 0), eol: (x == 7)});
    stream_on = 1'b1;
    run(2 * 98);

    fault_kind = 1; fx = 5; fy = 1;
    run(3 * 98);
    fault_kind = 2; fx = 4; fy = 1;
    run(3 * 98);
    fault_kind = 3; fx = 0; fy = 2;
    run(3 * 98);

    dis_armed = 1'b1;
    run(2 * 98);
    run(5);
    en_req = 1'b1;
    run(3 * 98);

    chk("underflow_pulses", uf_seen, 3);
    chk("pixel_23_seen", (seen_023 > 0) ? 1 : 0, 1);

    #2;
    tx_rst_n = 1'b0;
    #1;
    chk("midrst_de", tx_de, 0);
    chk("midrst_x", x_pos, 0);
    chk("midrst_y", y_pos, 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_ready", vif.s_ready, 0);
    chk("sb_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_timing_tx.md
# video_timing_tx

Video transmitter that regenerates pixel-clock DVI/HDMI-style timing (DE, HSYNC, VSYNC, 8-bit RGB) from a ready/valid pixel stream carrying frame and line markers. It is the transmit-side counterpart to the rx_* video input consumed by klt_tracker. It drives a file sink or TMDS encoder from processed frames. A free-running raster counter paces the output, and the block aligns to the stream's start-of-frame marker. On underflow it blanks and realigns.

## Interface
Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level

Ports:
- tx_pclk  in  1  pixel clock; all logic on rising edge
- tx_rst_n  in  1  asynchronous active-low reset
- enable  in  1  run raster; 0 forces IDLE
- s_pixel  in  24  {red[23:16], green[15:8], blue[7:0]}
- s_valid  in  1  s_pixel valid
- s_sof  in  1  pixel is (0,0) of a frame
- s_eol  in  1  pixel is last of a line
- s_ready  out  1  pixel accepted when s_valid & s_ready
- tx_de  out  1  data enable
- tx_hsync  out  1  horizontal sync
- tx_vsync  out  1  vertical sync
- tx_red, tx_green, tx_blue  out  8 each  pixel colour
- x_pos  out  12  column of pixel on tx_* outputs
- y_pos  out  11  line of pixel on tx_* outputs
- frame_start  out  1  one-cycle pulse with output raster position (0,0)
- locked  out  1  high in STREAM
- underflow  out  1  one-cycle pulse on stream error

## Operation
- Counters: h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1, where H_TOTAL = sum of the H params and V_TOTAL = sum of the V params.
  - h_cnt wraps to 0 and increments v_cnt; v_cnt wraps after V_TOTAL-1.
  - H_TOTAL must be ≤ 4096 and V_TOTAL ≤ 2048.
- Region order per line and per frame: active, front porch, sync, back porch.
  - active = h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - hsync active when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync active when V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC; vsync edges fall on h_cnt = 0.
- IDLE state (enable=0): counters held at 0, s_ready=0, outputs at reset values. enable=1 → ALIGN; counting starts that cycle.
- ALIGN state: counters run and the syncs are generated. tx_de follows active, and RGB is 0 (black).
  - s_ready=1 while the head pixel has s_sof=0, so non-SOF pixels are dropped.
  - s_ready=0 while s_valid & s_sof, so the SOF pixel is held.
  - → STREAM on the cycle where h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1 and s_valid & s_sof.
- STREAM state: s_ready = active, and there is no acceptance outside active.
  - Each active cycle consumes one pixel and drives it to the output.
  - Error → underflow pulse and → ALIGN. Errors are:
    - s_valid=0 in an active cycle;
    - s_sof=1 at a position other than (0,0);
    - s_eol value ≠ (h_cnt = H_ACTIVE-1).
  - The errored cycle and the rest of the frame output black.
  - A consumed pixel that caused an error is discarded.
- enable falling in any state → IDLE next cycle; there is no completion of the frame.
- locked = (state = STREAM), registered with the state.

## Timing
- Reset (async assert, sync release) gives:
  - tx_de=0, RGB=0, x_pos=0, y_pos=0, frame_start=0, underflow=0, locked=0, s_ready=0;
  - tx_hsync=~HS_POL, tx_vsync=~VS_POL;
  - state IDLE, counters 0.
- Reset mid-frame: the above takes effect immediately and the stream is not touched (s_ready=0).
- s_ready is combinational from state, counters and stream flags only, never from outputs.
- Output latency: 1 cycle.
  - tx_de, tx_hsync, tx_vsync, RGB, x_pos, y_pos and frame_start are all registered from the same counter values, so they stay mutually aligned.
  - A pixel accepted in cycle N appears on the outputs in cycle N+1.
- x_pos and y_pos equal the counter values of the previous cycle, including during blanking.
- frame_start pulses in ALIGN and STREAM, not in IDLE.
- underflow is registered and pulses at N+1 for an error in cycle N. locked falls in the same cycle.

## Test plan
Bench parameters: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, both polarities 1, giving a 98-cycle frame.
- Reset/idle: tx_rst_n=0 then 1, enable=0 for 50 cycles → all outputs at reset values, syncs 0, s_ready=0.
- Raster: enable=1 with no stream → tx_hsync high for x_pos 10..11. tx_vsync high for the whole of y_pos=5. tx_de high for 32 cycles per frame and RGB=0. frame_start pulses every 98 cycles.
- Lock and stream:
  - Stimulus: 2 junk pixels, then a continuously valid frame of pixel value = (y<<4)|x with correct sof/eol.
  - Required: junk dropped, locked=1 after the first wrap.
  - Required: the output at (x,y) is 0x0000yx in the lower byte, e.g. (3,2) → 0x000023, one cycle after acceptance.
- Underflow: drop s_valid at (5,1) in STREAM → underflow pulse, locked=0, black to frame end. Re-lock on the next SOF at the next wrap.
- Marker errors:
  - s_eol=1 at x=4 → underflow and ALIGN.
  - s_sof=1 at (0,2) → underflow.
- Enable drop mid-line at (3,1) → next cycle IDLE, tx_de=0, counters 0. Re-enable restarts the raster at (0,0).
